// File: rtl/result_if.sv
// Result reader bus: synchronous memory read port plus valid/ready output stream.
// The reader takes the master side; the memory and consumer take the slave side.
interface result_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr, mem_rd_en, out_data, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, out_data, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/result_reader.sv
// Streams result words 0..count-1 from the result memory onto a valid/ready port.
// Each entry costs one read cycle, one capture cycle and at least one hold cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; count is latched and clamped on start
// FETCH   | mem_rd_en high for this cycle only, at mem_addr
// CAPTURE | read data arrives; registered into out_data at cycle end
// HOLD    | out_valid high, out_data frozen until out_ready
// DONE    | one-cycle done pulse, then back to IDLE
module result_reader #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    result_if.master          bus,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_clamped;
    logic              is_last;

    assign count_clamped = (count > DEPTH) ? DEPTH : count;
    assign is_last       = ({1'b0, index} == (count_q - ONE_CNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            index         <= '0;
            count_q       <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count_q <= count_clamped;
                        busy    <= 1'b1;
                        if (count_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= S_FETCH;
                            index         <= '0;
                            bus.mem_addr  <= '0;
                            bus.mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    bus.out_data  <= bus.mem_rdata;
                    bus.out_valid <= 1'b1;
                    state         <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (is_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            index         <= index + ONE_ADDR;
                            bus.mem_addr  <= bus.mem_addr + ONE_ADDR;
                            bus.mem_rd_en <= 1'b1;
                            state         <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.mem_rd_en <= 1'b0;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: table of read passes plus stall, restart and reset sequences.
// A negedge monitor logs every memory read, accepted word and done pulse.
module tb_result_reader;
    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] count;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] mem [16];
    logic [23:0] q_words [$];
    logic [3:0]  q_addr [$];
    int          n_done;

    result_if #(.DATA_W(24), .ADDR_W(4)) bus ();

    result_reader #(.DATA_W(24), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_rd_en) q_addr.push_back(bus.mem_addr);
            if (bus.out_valid && bus.out_ready) q_words.push_back(bus.out_data);
            if (done) n_done++;
        end
    end

    typedef struct {
        logic [4:0] cnt;
        int         n_exp;
        int         cyc_exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_words.delete();
        q_addr.delete();
        n_done = 0;
    endtask

    // Called #1 after a rising edge; returns edges from start edge to the done cycle.
    task automatic run_pass(input logic [4:0] c, input bit hold_start, output int cyc);
        start = 1'b1;
        count = c;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL pass_timeout: got no done expected done within 200 cycles");
        end
        chk("busy_at_done", 32'(busy), 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_after", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int n_exp);
        chk({tag, "_nwords"}, 32'(q_words.size()), 32'(n_exp));
        chk({tag, "_nreads"}, 32'(q_addr.size()), 32'(n_exp));
        chk({tag, "_ndone"}, 32'(n_done), 32'd1);
        for (int k = 0; k < n_exp; k++) begin
            if (k < q_words.size()) chk({tag, "_word"}, 32'(q_words[k]), 32'h100000 + 32'(k));
            if (k < q_addr.size())  chk({tag, "_addr"}, 32'(q_addr[k]), 32'(k));
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   cyc;
        int   stall;

        vecs[0] = '{cnt: 5'd9,  n_exp: 9,  cyc_exp: 27};
        vecs[1] = '{cnt: 5'd16, n_exp: 16, cyc_exp: 48};
        vecs[2] = '{cnt: 5'd20, n_exp: 16, cyc_exp: 48};
        vecs[3] = '{cnt: 5'd0,  n_exp: 0,  cyc_exp: 0};
        vecs[4] = '{cnt: 5'd1,  n_exp: 1,  cyc_exp: 3};
        vecs[5] = '{cnt: 5'd5,  n_exp: 5,  cyc_exp: 15};

        for (int k = 0; k < 16; k++) mem[k] = 24'h100000 + 24'(k);
        reset         = 1'b1;
        start         = 1'b0;
        count         = '0;
        bus.out_ready = 1'b1;
        clear_log();

        #2;
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            clear_log();
            run_pass(vecs[v].cnt, 1'b0, cyc);
            chk("pass_cycles", 32'(cyc), 32'(vecs[v].cyc_exp));
            check_stream("pass", vecs[v].n_exp);
            repeat (2) @(posedge clk);
            #1;
        end

        // Back-pressure: stall word 1 for five cycles.
        clear_log();
        start = 1'b1;
        count = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        stall = 0;
        while (!done && cyc < 100) begin
            if ((stall == 0 && bus.out_valid && bus.out_data == 24'h100001) ||
                (stall > 0 && stall < 5)) begin
                bus.out_ready = 1'b0;
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data",  32'(bus.out_data),  32'h100001);
                chk("stall_rd_en", 32'(bus.mem_rd_en), 32'd0);
                stall++;
            end else begin
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_count",  32'(stall), 32'd5);
        chk("stall_cycles", 32'(cyc),   32'd14);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_stream("stall", 3);

        // start held high through FETCH/HOLD/DONE of a count=4 pass.
        clear_log();
        run_pass(5'd4, 1'b1, cyc);
        chk("restart_cycles", 32'(cyc), 32'd12);
        repeat (8) @(posedge clk);
        #1;
        chk("restart_idle", 32'(busy), 32'd0);
        check_stream("restart", 4);
        clear_log();
        run_pass(5'd2, 1'b0, cyc);
        check_stream("fresh", 2);

        // Asynchronous reset while word 2 is held.
        clear_log();
        start = 1'b1;
        count = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!(bus.out_valid && bus.out_data == 24'h100002) && cyc < 50) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_addr",  32'(bus.mem_addr),  32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_busy",  32'(busy),          32'd0);
        chk("async_addr",  32'(bus.mem_addr),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        clear_log();
        run_pass(5'd2, 1'b0, cyc);
        check_stream("post_rst", 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Reads the result-matrix memory back out and streams each entry to a downstream consumer (display/serial formatter).
- It is the read-side counterpart of the result write path, which stores 24-bit results at addresses 0,1,2,… after reset.
- Walks addresses 0..count-1 with a synchronous memory read, then presents each word on a valid/ready output handshake.

Parameters:
- DATA_W, 24, width of one result word.
- ADDR_W, 4, result memory address width; memory depth is 2**ADDR_W = 16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  begin one read pass; sampled only in IDLE.
- count  input  ADDR_W+1  number of entries to read (0..16); latched on accepted start.
- mem_addr  output  ADDR_W  result memory read address.
- mem_rd_en  output  1  read strobe; memory returns mem_rdata one cycle later.
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd_en.
- out_data  output  DATA_W  current result word.
- out_valid  output  1  out_data valid; held until accepted.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (async, any state): state=IDLE, mem_addr=0, mem_rd_en=0, out_data=0, out_valid=0, busy=0, done=0, index=0, latched count=0. Any in-flight read or un-accepted word is discarded; nothing is re-presented after reset.
- States are IDLE, FETCH, CAPTURE, HOLD and DONE. All outputs are registered.
- IDLE:
  - If start=1 at an edge, latch count. Values >16 are clamped to 16.
  - If latched count is 0, go to DONE.
  - Otherwise set index=0, mem_addr=0 and go to FETCH.
- FETCH: mem_rd_en=1 for exactly this cycle at mem_addr. Next state is CAPTURE.
- CAPTURE: mem_rd_en=0. At the end of the cycle, out_data<=mem_rdata and out_valid<=1. Next state is HOLD.
- HOLD: out_valid=1 and out_data stable until handshake.
  - On out_valid && out_ready, clear out_valid.
  - If index==count-1, go to DONE.
  - Otherwise index+1 and mem_addr+1, then go to FETCH.
- DONE: done=1 for this single cycle, busy=1. Next state is IDLE.
- Latency:
  - The edge that samples start enters FETCH.
  - out_valid first reads high after the 2nd following edge (3 cycles including the FETCH cycle).
  - With out_ready tied high, each entry costs 3 cycles. A count=N pass takes 3N+1 cycles from the start edge to the end of the done pulse.
- Back-pressure: out_ready low holds HOLD indefinitely, with no further memory reads; out_data must not change.
- start while busy: ignored, no queuing. start in the same cycle as DONE is also ignored; start is accepted only from IDLE.
- Address wrap: index and mem_addr never exceed count-1 ≤ 15, so no wrap occurs. count=16 reads addresses 0..15 exactly once.
- out_ready while out_valid=0: no effect.

Test Plan:
- Memory preloaded with word k = 24'h100000+k. Pulse start with count=9 and out_ready=1 -> 9 transfers of 24'h100000..24'h100008 in order, mem_addr 0..8, done pulses once 28 cycles after the start edge, busy low afterward.
- count=16, out_ready=1 -> addresses 0..15 each read once, last word 24'h10000F, no address 0 re-read after the last word; count=20 behaves identically (clamp).
- count=0 -> no mem_rd_en and no out_valid; done pulses on the cycle after the start edge; busy high for that single cycle only.
- count=3, out_ready low for 5 cycles while word 1 (24'h100001) is presented -> out_valid and out_data remain stable, mem_rd_en stays 0 during the stall, and all 3 words are delivered exactly once.
- start re-pulsed in FETCH, HOLD and DONE during a count=4 pass -> exactly one pass and one done pulse. A start in IDLE afterward runs a fresh pass beginning at address 0.
- Assert reset asynchronously mid-HOLD of word 2 -> out_valid, busy and mem_addr clear immediately without waiting for a clock edge. The next start with count=2 delivers 24'h100000 and 24'h100001.
